// File: rtl/axi_mag_squelch_gain.sv
// AXI-stream magnitude squelch and gain stage with hysteresis and hang timing.
// Two-stage pipeline with a shared enable, round-half-up and saturating output.
module axi_mag_squelch_gain #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned GAIN_FRAC  = 12,
  parameter int unsigned HANG_WIDTH = 16,
  parameter logic [7:0]  SR_GAIN    = 8'd192,
  parameter logic [7:0]  SR_OPEN    = 8'd193,
  parameter logic [7:0]  SR_CLOSE   = 8'd194,
  parameter logic [7:0]  SR_HANG    = 8'd195
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             squelch_open
);

  localparam int unsigned PW = WIDTH + GAIN_WIDTH;
  localparam int unsigned RW = PW + 1 - GAIN_FRAC;
  localparam logic [PW:0]           HALF     = {{PW{1'b0}}, 1'b1} << (GAIN_FRAC - 1);
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = {{(GAIN_WIDTH-1){1'b0}}, 1'b1} << GAIN_FRAC;
  localparam logic [HANG_WIDTH-1:0] CNT_ONE  = {{(HANG_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPEN,
    ST_HANG
  } state_t;

  state_t                state, state_nxt;
  logic [HANG_WIDTH-1:0] hang_cnt, cnt_nxt;

  logic [GAIN_WIDTH-1:0] gain_r;
  logic [WIDTH-1:0]      open_thr;
  logic [WIDTH-1:0]      close_thr;
  logic [HANG_WIDTH-1:0] hang_len;

  logic                  en;
  logic                  accept;
  logic [WIDTH-1:0]      gated;
  logic [PW-1:0]         prod;

  logic                  s1_valid;
  logic                  s1_last;
  logic [PW-1:0]         s1_prod;

  logic [PW:0]           sum;
  logic [RW-1:0]         rnd;
  logic [WIDTH-1:0]      sat;
  logic                  unused_bits;

  assign en       = ~o_tvalid | o_tready;
  assign i_tready = en;
  assign accept   = i_tvalid & en;

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_r    <= GAIN_ONE;
      open_thr  <= '0;
      close_thr <= '0;
      hang_len  <= '0;
    end else if (set_stb) begin
      case (set_addr)
        SR_GAIN:  gain_r    <= set_data[GAIN_WIDTH-1:0];
        SR_OPEN:  open_thr  <= set_data[WIDTH-1:0];
        SR_CLOSE: close_thr <= set_data[WIDTH-1:0];
        SR_HANG:  hang_len  <= set_data[HANG_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_CLOSED;
      hang_cnt     <= '0;
      squelch_open <= 1'b0;
    end else begin
      state        <= state_nxt;
      hang_cnt     <= cnt_nxt;
      squelch_open <= (state != ST_CLOSED);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = hang_cnt;
    if (accept) begin
      case (state)
        ST_CLOSED: begin
          if (i_tdata > open_thr) state_nxt = ST_OPEN;
        end
        ST_OPEN: begin
          if (i_tdata < close_thr) begin
            if (hang_len == '0) begin
              state_nxt = ST_CLOSED;
            end else begin
              state_nxt = ST_HANG;
              cnt_nxt   = hang_len;
            end
          end
        end
        ST_HANG: begin
          if (i_tdata >= close_thr)   state_nxt = ST_OPEN;
          else if (hang_cnt <= CNT_ONE) state_nxt = ST_CLOSED;
          else                        cnt_nxt   = hang_cnt - CNT_ONE;
        end
        default: state_nxt = ST_CLOSED;
      endcase
    end
  end

  // Gating looks at the post-update state so the sample that opens the squelch passes.
  assign gated = (state_nxt != ST_CLOSED) ? i_tdata : '0;
  assign prod  = {{GAIN_WIDTH{1'b0}}, gated} * {{WIDTH{1'b0}}, gain_r};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= i_tvalid;
      s1_last  <= i_tlast;
      s1_prod  <= prod;
    end
  end

  assign sum = {1'b0, s1_prod} + HALF;
  assign rnd = sum[PW:GAIN_FRAC];
  assign sat = (|rnd[RW-1:WIDTH]) ? '1 : rnd[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (en) begin
      o_tvalid <= s1_valid;
      o_tdata  <= sat;
      o_tlast  <= s1_last;
    end
  end

  assign unused_bits = ^{set_data, sum[GAIN_FRAC-1:0]};

endmodule

// File: tb/tb_axi_mag_squelch_gain.sv
// Self-checking bench for axi_mag_squelch_gain: directed test-plan cases plus
// randomized traffic scored against a behavioural model of the squelch and gain rules.
module tb_axi_mag_squelch_gain;

  localparam int GF = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [15:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [15:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        squelch_open;

  always #5 clk = ~clk;

  axi_mag_squelch_gain #(
    .WIDTH(16), .GAIN_WIDTH(16), .GAIN_FRAC(GF), .HANG_WIDTH(16),
    .SR_GAIN(8'd192), .SR_OPEN(8'd193), .SR_CLOSE(8'd194), .SR_HANG(8'd195)
  ) dut (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .squelch_open(squelch_open)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: squelch is "closed", "open" or "hanging".
  localparam int CLOSED = 0, OPEN = 1, HANGING = 2;
  typedef struct { logic [15:0] data; logic last; int acc; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] got_q[$];
  exp_t        e;
  int          m_state, m_cnt, m_open, m_close, m_hang, cyc;
  longint      m_gain;
  bit          sq_exp, sq_next, lat_chk, rand_rdy, stall_seen;
  logic [17:0] stall_snap;

  function automatic void model_reset();
    m_state = CLOSED; m_cnt = 0; m_gain = 4096;
    m_open = 0; m_close = 0; m_hang = 0; sq_exp = 0;
  endfunction

  function automatic logic [15:0] model_step(input int m);
    longint r;
    if (m_state == CLOSED) begin
      if (m > m_open) m_state = OPEN;
    end else if (m_state == OPEN) begin
      if (m < m_close) begin
        if (m_hang == 0) m_state = CLOSED;
        else begin m_state = HANGING; m_cnt = m_hang; end
      end
    end else begin
      if (m >= m_close)  m_state = OPEN;
      else if (m_cnt <= 1) m_state = CLOSED;
      else m_cnt--;
    end
    r = (m_state != CLOSED) ? longint'(m) : 0;
    r = (r * m_gain + (longint'(1) << (GF - 1))) >> GF;
    if (r > 65535) r = 65535;
    return 16'(r);
  endfunction

  initial model_reset();

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      model_reset();
      exp_q.delete();
      stall_seen = 0;
    end else begin
      chk("squelch_open", squelch_open, sq_exp);
      if (stall_seen) chk("stall_hold", {o_tvalid, o_tlast, o_tdata}, stall_snap);
      stall_seen = o_tvalid && !o_tready;
      stall_snap = {o_tvalid, o_tlast, o_tdata};
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", o_tdata, e.data);
          chk("last", o_tlast, e.last);
          if (lat_chk) chk("latency", cyc - e.acc, 2);
          got_q.push_back(o_tdata);
        end
      end
      sq_next = (m_state != CLOSED);
      if (i_tvalid && i_tready) begin
        e.data = model_step(int'(i_tdata));
        e.last = i_tlast;
        e.acc  = cyc;
        exp_q.push_back(e);
      end
      if (set_stb) begin
        case (set_addr)
          8'd192: m_gain  = longint'(set_data[15:0]);
          8'd193: m_open  = int'(set_data[15:0]);
          8'd194: m_close = int'(set_data[15:0]);
          8'd195: m_hang  = int'(set_data[15:0]);
          default: ;
        endcase
      end
      sq_exp = sq_next;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) o_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic send(input logic [15:0] m, input logic l);
    int  n;
    bit  acc;
    n = 0;
    i_tvalid = 1'b1; i_tdata = m; i_tlast = l;
    do begin
      @(negedge clk);
      acc = i_tready;
      tick();
      set_stb = 1'b0;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    tick(); tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [16:0] got_at(input int i);
    if (i < got_q.size()) return {1'b0, got_q[i]};
    return 17'h1ffff;
  endfunction

  initial begin
    lat_chk = 1; rand_rdy = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_sq", squelch_open, 0);

    // Unity gain defaults
    got_q.delete();
    send(16'd1000, 0); send(16'd5, 0); send(16'd65535, 1);
    drain();
    chk("t1_0", got_at(0), 1000);
    chk("t1_1", got_at(1), 5);
    chk("t1_2", got_at(2), 65535);
    chk("t1_sq", squelch_open, 1);

    // Gain x2 with saturation, then x0.5 with round-half-up
    got_q.delete();
    wr(8'd192, 32'h2000);
    send(16'd1000, 0); send(16'd40000, 1);
    wr(8'd192, 32'h0800);
    send(16'd3, 0); send(16'd2, 0); send(16'd1, 1);
    drain();
    chk("t2_x2", got_at(0), 2000);
    chk("t2_sat", got_at(1), 65535);
    chk("t2_h3", got_at(2), 2);
    chk("t2_h2", got_at(3), 1);
    chk("t2_h1", got_at(4), 1);

    // Hysteresis without hang
    pulse_reset();
    wr(8'd193, 32'd100); wr(8'd194, 32'd50); wr(8'd195, 32'd0);
    got_q.delete();
    send(16'd80, 0); send(16'd120, 0); send(16'd70, 0); send(16'd40, 0); send(16'd80, 1);
    drain();
    chk("t3_0", got_at(0), 0);
    chk("t3_1", got_at(1), 120);
    chk("t3_2", got_at(2), 70);
    chk("t3_3", got_at(3), 0);
    chk("t3_4", got_at(4), 0);
    chk("t3_sq", squelch_open, 0);

    // Hang of two samples, then re-open from hang
    wr(8'd195, 32'd2);
    got_q.delete();
    send(16'd120, 0); send(16'd40, 0); send(16'd30, 0); send(16'd20, 0); send(16'd10, 1);
    send(16'd120, 0); send(16'd40, 0); send(16'd60, 0); send(16'd40, 1);
    drain();
    chk("t4_0", got_at(0), 120);
    chk("t4_1", got_at(1), 40);
    chk("t4_2", got_at(2), 30);
    chk("t4_3", got_at(3), 0);
    chk("t4_4", got_at(4), 0);
    chk("t4_5", got_at(5), 120);
    chk("t4_6", got_at(6), 40);
    chk("t4_7", got_at(7), 60);
    chk("t4_8", got_at(8), 40);
    chk("t4_sq", squelch_open, 1);

    // Randomized traffic, backpressure and settings writes
    lat_chk = 0; rand_rdy = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      if ($urandom_range(0, 9) == 0) begin
        set_stb = 1'b1;
        case ($urandom_range(0, 4))
          0: begin set_addr = 8'd192;
                   set_data = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 'h3000)); end
          1: begin set_addr = 8'd193; set_data = 32'($urandom_range(0, 1500)); end
          2: begin set_addr = 8'd194; set_data = 32'($urandom_range(0, 1500)); end
          3: begin set_addr = 8'd195; set_data = 32'($urandom_range(0, 4)); end
          default: begin set_addr = 8'd200; set_data = $urandom; end
        endcase
      end
      send(($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000)),
           1'($urandom_range(0, 7) == 0));
    end
    rand_rdy = 0; o_tready = 1'b1;
    drain();

    // Reset with a full, stalled pipeline while hanging
    wr(8'd192, 32'h1000); wr(8'd193, 32'd100); wr(8'd194, 32'd50); wr(8'd195, 32'd2);
    o_tready = 1'b0;
    send(16'd120, 0); send(16'd40, 1);
    chk("t7_full", {o_tvalid, i_tready}, 2'b10);
    pulse_reset();
    chk("t7_tvalid", o_tvalid, 0);
    chk("t7_sq", squelch_open, 0);
    o_tready = 1'b1;
    lat_chk = 1;
    got_q.delete();
    send(16'd1000, 1);
    drain();
    chk("t7_post", got_at(0), 1000);
    chk("t7_cnt", got_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
